// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial output bundle for piso_serializer
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d_in;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             busy;
  logic             done;

  // Requester side: offers words, observes the serial line and status.
  modport master (
    output d_in,
    output load_valid,
    input  load_ready,
    input  sout,
    input  busy,
    input  done
  );

  // Serializer side.
  modport slave (
    input  d_in,
    input  load_valid,
    output load_ready,
    output sout,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - MSB-first parallel-in serial-out shifter, optional even parity via PISO_PARITY_EN
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  piso_serializer_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  // bit_cnt holds how many frame bits have been put on sout, including the current one.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             sout_r;
  logic             busy_r;
  logic             ready_r;
  logic             done_r;
`ifdef PISO_PARITY_EN
  logic             parity_r;
`endif

  // Outputs are all registered; busy and load_ready are always written as a complementary pair.
  assign bus.sout       = sout_r;
  assign bus.busy       = busy_r;
  assign bus.load_ready = ready_r;
  assign bus.done       = done_r;

  // Frame FSM: the MSB is driven straight from d_in on the accepting edge, the rest come from shift_reg.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      sout_r    <= 1'b1;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            state     <= SHIFT;
            sout_r    <= bus.d_in[WIDTH-1];
            shift_reg <= {bus.d_in[WIDTH-2:0], 1'b0};
            bit_cnt   <= ONE_CNT;
            busy_r    <= 1'b1;
            ready_r   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_r  <= ^bus.d_in;
`endif
          end
        end
        SHIFT: begin
          if (bit_cnt == LAST_CNT) begin
            state   <= IDLE;
            sout_r  <= 1'b1;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b1;
            bit_cnt <= '0;
`ifdef PISO_PARITY_EN
          end else if (bit_cnt == CNT_W'(WIDTH)) begin
            sout_r  <= parity_r;
            bit_cnt <= bit_cnt + ONE_CNT;
`endif
          end else begin
            sout_r    <= shift_reg[WIDTH-1];
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            bit_cnt   <= bit_cnt + ONE_CNT;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   done_cnt;

  piso_serializer_if #(.WIDTH(8)) bus ();

  piso_serializer #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_sout"},  32'(bus.sout),       32'd1);
    chk({tag, "_busy"},  32'(bus.busy),       32'd0);
    chk({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
    chk({tag, "_done"},  32'(bus.done),       32'(exp_done));
  endtask

  function automatic logic exp_bit(input logic [7:0] data, input int i);
    if (i < 8) return data[7-i];
    return ^data;
  endfunction

  // Checks bits first_bit..FL-1 starting in the current cycle, then the done cycle.
  // At bit inject_at a one-cycle load of 8'h00 is offered (ignored while busy).
  task automatic check_frame(input string tag, input logic [7:0] data,
                             input int first_bit, input int inject_at);
    for (int i = first_bit; i < FL; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), 32'(bus.sout), 32'(exp_bit(data, i)));
      chk($sformatf("%s_busy%0d", tag, i), 32'({bus.busy, bus.load_ready, bus.done}), 32'b100);
      if (i == inject_at) begin
        bus.d_in       = 8'h00;
        bus.load_valid = 1'b1;
      end
      step();
      if (i == inject_at) bus.load_valid = 1'b0;
    end
    chk_idle({tag, "_end"}, 1'b1);
  endtask

  task automatic load_word(input logic [7:0] data);
    bus.d_in       = data;
    bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;

    // Reset with a load offered: reset wins, nothing starts.
    reset          = 1'b0;
    bus.load_valid = 1'b1;
    bus.d_in       = 8'hFF;
    step();
    chk_idle("rst1", 1'b0);
    step();
    chk_idle("rst2", 1'b0);
    reset          = 1'b1;
    bus.load_valid = 1'b0;
    step();
    chk_idle("post_rst", 1'b0);

    // Single frame 8'hA5.
    load_word(8'hA5);
    check_frame("a5", 8'hA5, 0, -1);
    step();
    chk_idle("a5_after", 1'b0);

    // Back-to-back 8'h81 then 8'h7E with load_valid held high.
    bus.d_in       = 8'h81;
    bus.load_valid = 1'b1;
    step();
    check_frame("b2b_81", 8'h81, 0, -1);
    bus.d_in = 8'h7E;
    step();
    bus.load_valid = 1'b0;
    check_frame("b2b_7e", 8'h7E, 0, -1);
    step();
    chk_idle("b2b_after", 1'b0);
    chk("b2b_done_cnt", 32'(done_cnt), 32'd3);

    // Load offered mid-frame must be ignored.
    load_word(8'hFF);
    check_frame("busy_ff", 8'hFF, 0, 3);
    step();
    chk_idle("busy_after", 1'b0);
    step();
    chk_idle("busy_after2", 1'b0);

    // Reset during bit 4 of 8'h3C: no done pulse.
    load_word(8'h3C);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("abort_bit%0d", i), 32'(bus.sout), 32'(exp_bit(8'h3C, i)));
      if (i < 4) step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_idle("abort_rst", 1'b0);
    step();
    chk_idle("abort_rst2", 1'b0);
    chk("abort_done_cnt", 32'(done_cnt), 32'd4);

    load_word(8'hC3);
    check_frame("c3", 8'hC3, 0, -1);

    // Parity-bearing word: frame length FL and, with parity, trailing bit 1.
    step();
    load_word(8'h07);
    check_frame("p07", 8'h07, 0, -1);
    step();
    chk_idle("p07_after", 1'b0);
    chk("total_done_cnt", 32'(done_cnt), 32'd6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel data word width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-low (reset==0 clears state at the next rising clk).
REQ-004 SHALL have port d_in  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
REQ-005 SHALL have port load_valid  input  1  requester offers d_in.
REQ-006 SHALL have port load_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port sout  output  1  serial data line; idle level 1.
REQ-008 SHALL have port busy  output  1  a frame is being shifted out.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 SHALL implement two states: IDLE and SHIFT.
REQ-011 In IDLE: load_ready=1, busy=0, sout=1.
REQ-012 Load accepted when load_valid==1 and load_ready==1 at a rising edge; d_in captured into an internal shift register and state moves to SHIFT on that edge.
REQ-013 In SHIFT: load_ready=0, busy=1; load_valid ignored and d_in not sampled.
REQ-014 Bits leave MSB first; each bit held on sout for exactly one clk cycle; d_in[WIDTH-1] appears in the first cycle after the accepting edge.
REQ-015 Frame length SHALL be WIDTH bit-cycles (WIDTH+1 with parity, see Configuration); a bit counter of ceil(log2(WIDTH+2)) bits tracks position.
REQ-016 On the edge ending the last bit-cycle, state returns to IDLE and done=1 for exactly that following cycle; sout=1, load_ready=1 in that cycle.
REQ-017 A load accepted in the done cycle SHALL start the next frame; minimum inter-frame gap is therefore one idle cycle at sout=1.
REQ-018 done SHALL never assert outside the single cycle after a completed frame; busy and load_ready SHALL always be complementary.
REQ-019 An aborted frame (reset mid-SHIFT) SHALL NOT produce done.

Reset
REQ-020 While reset==0 at a rising edge: state=IDLE, shift register=0, counter=0, sout=1, busy=0, done=0, load_ready=1 from the next cycle.
REQ-021 Reset SHALL take priority over an accepted load in the same cycle (load discarded).
REQ-022 Outputs before the first reset edge are undefined; the bench applies reset for at least 2 cycles.

Configuration
REQ-023 Macro PISO_PARITY_EN SHALL, when defined, append one even-parity bit (XOR of all WIDTH data bits) after the LSB, making the frame WIDTH+1 bit-cycles; done follows the parity bit.
REQ-024 Without PISO_PARITY_EN, the frame is exactly WIDTH data bit-cycles and no parity logic is present.

Verification
REQ-025 Reset: hold reset=0 for 2 cycles with load_valid=1, d_in=8'hFF -> sout=1, busy=0, done=0, load_ready=1; no frame starts.
REQ-026 Single frame, WIDTH=8, d_in=8'hA5 -> sout sequence 1,0,1,0,0,1,0,1 over 8 cycles (plus parity 0 when PISO_PARITY_EN), then done=1 for one cycle, sout=1.
REQ-027 Back-to-back: 8'h81 then 8'h7E with load_valid held high -> second frame starts in cycle after done; exactly one idle sout=1 cycle between frames; two done pulses.
REQ-028 Load while busy: pulse load_valid with d_in=8'h00 mid-frame of 8'hFF -> ignored; sout stays 1 for all 8 bits; no extra frame.
REQ-029 Reset mid-frame: drive reset=0 during bit 4 of 8'h3C -> next cycle IDLE, sout=1, no done pulse; subsequent load of 8'hC3 serializes correctly.
REQ-030 Parity build: with PISO_PARITY_EN, d_in=8'h07 -> parity bit 1, frame 9 bit-cycles; without it, 8 bit-cycles.
